// File: rtl/time_keeper.sv
// time_keeper: 24-hour BCD time-of-day core with adjust, chime and day carry.
// Divider square waves are treated as data, synchronised and edge-detected.
module time_keeper #(
    parameter int CHIME_EN    = 1,
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk_50m,
    input  logic       cr,
    input  logic       clk_1hz,
    input  logic       clk_2hz,
    input  logic       en,
    input  logic       adj_hour,
    input  logic       adj_min,
    output logic [3:0] hour_h,
    output logic [3:0] hour_l,
    output logic [3:0] min_h,
    output logic [3:0] min_l,
    output logic [3:0] sec_h,
    output logic [3:0] sec_l,
    output logic       chime_lo,
    output logic       chime_hi,
    output logic       carry_day
);

    localparam int S = SYNC_STAGES;

    logic [S-1:0] s1hz_q, s1hz_d;
    logic [S-1:0] s2hz_q, s2hz_d;
    logic [S-1:0] shr_q, shr_d;
    logic [S-1:0] smin_q, smin_d;
    logic [S:0]   fill_q, fill_d;
    logic         e1hz_q, e1hz_d;
    logic         e2hz_q, e2hz_d;

    logic [3:0] hour_h_q, hour_h_d;
    logic [3:0] hour_l_q, hour_l_d;
    logic [3:0] min_h_q, min_h_d;
    logic [3:0] min_l_q, min_l_d;
    logic [3:0] sec_h_q, sec_h_d;
    logic [3:0] sec_l_q, sec_l_d;
    logic       chime_lo_q, chime_lo_d;
    logic       chime_hi_q, chime_hi_d;
    logic       carry_q, carry_d;

    logic tick_1s, tick_h;
    logic adj_h, adj_m, adjust;
    logic run_tick, adj_tick;
    logic sec_wrap, min_wrap, hour_wrap;
    logic inc_sec, inc_min, inc_hour;

    // Synchroniser shift, edge history, and a settle mask that blocks
    // ticks until the chains and edge flops hold real post-reset input
    always_comb begin
        s1hz_d = {s1hz_q[S-2:0], clk_1hz};
        s2hz_d = {s2hz_q[S-2:0], clk_2hz};
        shr_d  = {shr_q[S-2:0], adj_hour};
        smin_d = {smin_q[S-2:0], adj_min};
        fill_d = {fill_q[S-1:0], 1'b1};
        e1hz_d = s1hz_q[S-1];
        e2hz_d = s2hz_q[S-1];
    end

    assign tick_1s = s1hz_q[S-1] & ~e1hz_q & fill_q[S];
    assign tick_h  = s2hz_q[S-1] & ~e2hz_q & fill_q[S];
    assign adj_h   = shr_q[S-1];
    assign adj_m   = smin_q[S-1];
    assign adjust  = adj_h | adj_m;

    assign run_tick  = tick_1s & ~adjust & en;
    assign adj_tick  = tick_h & adjust;
    assign sec_wrap  = (sec_h_q == 4'd5) && (sec_l_q == 4'd9);
    assign min_wrap  = (min_h_q == 4'd5) && (min_l_q == 4'd9);
    assign hour_wrap = (hour_h_q == 4'd2) && (hour_l_q == 4'd3);

    assign inc_sec  = run_tick;
    assign inc_min  = (run_tick & sec_wrap) | (adj_tick & adj_m);
    assign inc_hour = (run_tick & sec_wrap & min_wrap) | (adj_tick & adj_h);

    // BCD field increments; adjust paths never feed the carry chain
    always_comb begin
        sec_h_d  = sec_h_q;
        sec_l_d  = sec_l_q;
        min_h_d  = min_h_q;
        min_l_d  = min_l_q;
        hour_h_d = hour_h_q;
        hour_l_d = hour_l_q;
        if (inc_sec) begin
            if (sec_l_q == 4'd9) begin
                sec_l_d = 4'd0;
                sec_h_d = sec_wrap ? 4'd0 : sec_h_q + 4'd1;
            end else begin
                sec_l_d = sec_l_q + 4'd1;
            end
        end
        if (inc_min) begin
            if (min_l_q == 4'd9) begin
                min_l_d = 4'd0;
                min_h_d = min_wrap ? 4'd0 : min_h_q + 4'd1;
            end else begin
                min_l_d = min_l_q + 4'd1;
            end
        end
        if (inc_hour) begin
            if (hour_wrap) begin
                hour_h_d = 4'd0;
                hour_l_d = 4'd0;
            end else if (hour_l_q == 4'd9) begin
                hour_h_d = hour_h_q + 4'd1;
                hour_l_d = 4'd0;
            end else begin
                hour_l_d = hour_l_q + 4'd1;
            end
        end
    end

    // Day carry and chime flags decoded from the current registered time
    always_comb begin
        carry_d    = run_tick & sec_wrap & min_wrap & hour_wrap;
        chime_lo_d = (CHIME_EN != 0) && min_wrap && (sec_h_q == 4'd5) &&
                     ((sec_l_q == 4'd1) || (sec_l_q == 4'd3) ||
                      (sec_l_q == 4'd5) || (sec_l_q == 4'd7));
        chime_hi_d = (CHIME_EN != 0) && min_wrap && sec_wrap;
    end

    // State registers, all cleared by the asynchronous reset
    always_ff @(posedge clk_50m or negedge cr) begin
        if (!cr) begin
            s1hz_q     <= '0;
            s2hz_q     <= '0;
            shr_q      <= '0;
            smin_q     <= '0;
            fill_q     <= '0;
            e1hz_q     <= 1'b0;
            e2hz_q     <= 1'b0;
            hour_h_q   <= 4'd0;
            hour_l_q   <= 4'd0;
            min_h_q    <= 4'd0;
            min_l_q    <= 4'd0;
            sec_h_q    <= 4'd0;
            sec_l_q    <= 4'd0;
            chime_lo_q <= 1'b0;
            chime_hi_q <= 1'b0;
            carry_q    <= 1'b0;
        end else begin
            s1hz_q     <= s1hz_d;
            s2hz_q     <= s2hz_d;
            shr_q      <= shr_d;
            smin_q     <= smin_d;
            fill_q     <= fill_d;
            e1hz_q     <= e1hz_d;
            e2hz_q     <= e2hz_d;
            hour_h_q   <= hour_h_d;
            hour_l_q   <= hour_l_d;
            min_h_q    <= min_h_d;
            min_l_q    <= min_l_d;
            sec_h_q    <= sec_h_d;
            sec_l_q    <= sec_l_d;
            chime_lo_q <= chime_lo_d;
            chime_hi_q <= chime_hi_d;
            carry_q    <= carry_d;
        end
    end

    assign hour_h    = hour_h_q;
    assign hour_l    = hour_l_q;
    assign min_h     = min_h_q;
    assign min_l     = min_l_q;
    assign sec_h     = sec_h_q;
    assign sec_l     = sec_l_q;
    assign chime_lo  = chime_lo_q;
    assign chime_hi  = chime_hi_q;
    assign carry_day = carry_q;

endmodule

// File: doc/time_keeper.md
Name: time_keeper

Overview:
- BCD time-of-day core (HH:MM:SS, 24-hour) sitting directly downstream of the clock divider.
- Consumes the divider's clk_1hz and clk_2hz square waves as data inputs, not as clocks. It synchronises them and edge-detects them into single-cycle ticks in the clk_50m domain.
- Drives BCD digits to the display scanner, hourly-chime flags to the buzzer stage, and a day-carry pulse.

Parameters:
- CHIME_EN, 1, 1 enables chime_lo/chime_hi decode; 0 ties both low.
- SYNC_STAGES, 2, flip-flop depth of each input synchroniser; legal values are 2 or more.

Ports:
- clk_50m  in  1  system clock, sole clock of the block.
- cr  in  1  asynchronous active-low reset.
- clk_1hz  in  1  1 Hz square wave from the divider; asynchronous to this block.
- clk_2hz  in  1  2 Hz square wave from the divider; asynchronous to this block.
- en  in  1  normal counting enable, level.
- adj_hour  in  1  hour-adjust request, level; asynchronous, synchronised internally.
- adj_min  in  1  minute-adjust request, level; asynchronous, synchronised internally.
- hour_h  out  4  hour tens, BCD 0..2.
- hour_l  out  4  hour units, BCD 0..9.
- min_h  out  4  minute tens, BCD 0..5.
- min_l  out  4  minute units, BCD 0..9.
- sec_h  out  4  second tens, BCD 0..5.
- sec_l  out  4  second units, BCD 0..9.
- chime_lo  out  1  low-tone chime flag.
- chime_hi  out  1  high-tone chime flag.
- carry_day  out  1  one-cycle pulse on 23:59:59 -> 00:00:00.

Behaviour:
- Clock and reset
  - Single clock: clk_50m. Reset cr is asynchronous and active-low.
  - While cr=0, every register is cleared: digits read 00:00:00, chime_lo=0, chime_hi=0, carry_day=0, all synchroniser and edge-detect flops 0.
  - A reset asserted mid-operation takes effect immediately. No tick pending at the moment of reset is honoured after release.
- Input conditioning
  - clk_1hz, clk_2hz, adj_hour and adj_min each pass through a SYNC_STAGES flip-flop synchroniser.
  - tick_1s = synchronised clk_1hz AND NOT its value delayed by one cycle. tick_h is derived the same way from clk_2hz.
  - Each tick is high for exactly one clk_50m cycle per input rising edge. Falling edges produce nothing.
  - Latency with SYNC_STAGES=2: let E0 be the first clk_50m edge at which clk_1hz is sampled high. The time registers update at edge E0+2.
- Mode select, evaluated each cycle on the synchronised adjust levels
  - ADJUST (adj_hour=1 or adj_min=1): normal counting is suspended and seconds are frozen. On each tick_h:
    - if adj_hour=1, hours increment modulo 24 (23 -> 00);
    - if adj_min=1, minutes increment modulo 60 (59 -> 00).
  - Adjust increments never carry: the minute wrap does not touch hours, and the hour wrap does not pulse carry_day.
  - Both adjust inputs high: both fields increment on the same tick_h.
  - RUN (no adjust, en=1): each tick_1s increments seconds with full carry chain sec -> min -> hour. Both BCD digits of a field update in the same cycle.
  - HOLD (no adjust, en=0): time is frozen. tick_1s is discarded, not queued.
  - A tick_1s arriving in the same cycle as an adjust is discarded; the adjust takes priority.
- Arithmetic
  - Units digits wrap 9 -> 0 with carry to the tens digit.
  - Seconds and minutes wrap 59 -> 00. Hours wrap 23 -> 00; 09 -> 10 and 19 -> 20 are normal BCD carries.
  - Digits only ever hold legal BCD, because the only writes are reset and increment.
- carry_day
  - Asserted for exactly one cycle, the cycle after a RUN tick moves the time from 23:59:59 to 00:00:00.
  - Never asserted in ADJUST.
- Chime (CHIME_EN=1)
  - Flags are registered from the time registers, so they change one cycle after the time changes.
  - chime_lo=1 while the time is MM=59 with SS in {51, 53, 55, 57}.
  - chime_hi=1 while the time is MM=59 with SS=59.
  - Both flags are otherwise 0 and are never high together.
  - Flags follow the displayed time in all modes, including HOLD and ADJUST.

Test Plan:
- Reset and count: cr low 5 cycles then high, en=1, drive 61 clk_1hz edges -> digits 00:01:01, carry_day never high; each update occurs exactly 2 clk_50m edges after the first edge sampling clk_1hz high.
- Day rollover: preload 23:59:58 via adjust plus counting, 2 clk_1hz edges -> 23:59:59 then 00:00:00, carry_day high for exactly 1 cycle.
- Chime window: run from 00:58:50 to 01:00:01 -> chime_lo high during 00:59:51, :53, :55 and :57, chime_hi high only during 00:59:59, each flag lagging its time update by 1 cycle; all flags 0 at 01:00:00.
- Adjust without carry: time 23:59:30, hold adj_min for 2 clk_2hz edges then adj_hour for 1 edge -> 00:01:30; seconds frozen at 30 throughout; carry_day stays 0; clk_1hz edges during adjust are ignored.
- Hold and collision: en=0 for 10 clk_1hz edges -> time unchanged; clk_1hz and clk_2hz edges aligned with adj_min=1 -> minute +1, seconds unchanged.
- Async reset mid-run: assert cr asynchronously at 12:34:56 between clock edges -> outputs read 00:00:00 immediately; after release, no spurious tick occurs while clk_1hz is held high.
